// File: rtl/mlp_layer_seq.sv
// Serial fully-connected layer: one signed MAC walks N_OUT neurons over N_IN inputs.
// Optional argmax tracker enabled with MLP_LAYER_ARGMAX_EN.
module mlp_layer_seq #(
  parameter  int DATA_W   = 8,
  parameter  int N_IN     = 8,
  parameter  int N_OUT    = 8,
  parameter  int FRAC     = 4,
  parameter  int ACT_MODE = 1,
  localparam int ACC_W    = 2*DATA_W + $clog2(N_IN) + 1,
  localparam int DEPTH    = N_OUT*N_IN + N_OUT,
  localparam int CA_W     = $clog2(DEPTH),
  localparam int IDX_W    = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CA_W-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]      cfg_wdata,
  output logic                   cfg_busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
`ifdef MLP_LAYER_ARGMAX_EN
  output logic [IDX_W-1:0]       out_argmax,
`endif
  output logic                   out_last
);

  localparam int K_W = $clog2(N_IN);
  localparam int PW  = 2*DATA_W;
  localparam int SMAX_I = (1 <<< (DATA_W-1)) - 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(SMAX_I);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ACT,
    OUT
  } state_e;

  state_e                  state_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       x_q [N_IN];
  logic [IDX_W-1:0]        n_q;
  logic [K_W-1:0]          k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [IDX_W-1:0]        out_idx_q;

  logic                    idle;
  logic                    hs;
  logic                    cfg_ok;
  logic                    n_last;
  logic                    k_last;
  logic [IDX_W-1:0]        n_nxt;
  logic signed [DATA_W-1:0] x_k;
  logic signed [DATA_W-1:0] w_k;
  logic signed [DATA_W-1:0] b_sel;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_sh;
  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] sat;
  logic [DATA_W-1:0]       act;

  always_comb begin
    idle   = (state_q == IDLE);
    hs     = idle & in_valid;
    cfg_ok = idle & cfg_we & (int'(cfg_addr) < DEPTH);
    n_last = (n_q == IDX_W'(N_OUT-1));
    k_last = (k_q == K_W'(N_IN-1));
    // Bias for the neuron about to start: n=0 from IDLE, n+1 from OUT
    n_nxt  = (idle | n_last) ? '0 : n_q + 1'b1;
    x_k    = x_q[k_q];
    w_k    = mem_q[CA_W'(int'(n_q)*N_IN + int'(k_q))];
    b_sel  = mem_q[CA_W'(N_OUT*N_IN + int'(n_nxt))];
    prod     = x_k * w_k;
    prod_ext = ACC_W'(prod);
    bias_sh  = ACC_W'(b_sel) <<< FRAC;
    r        = acc_q >>> FRAC;
    if (ACT_MODE == 1 && r[ACC_W-1]) begin
      sat = '0;
    end else if (r > SMAX) begin
      sat = SMAX;
    end else if (r < SMIN) begin
      sat = SMIN;
    end else begin
      sat = r;
    end
    act = sat[DATA_W-1:0];
  end

  // Coefficient RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      mem_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int k = 0; k < N_IN; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            for (int k = 0; k < N_IN; k++) begin
              x_q[k] <= in_data[k*DATA_W +: DATA_W];
            end
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= bias_sh;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          if (k_last) begin
            state_q <= ACT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ACT: begin
          out_data_q  <= act;
          out_idx_q   <= n_q;
          out_last_q  <= n_last;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q <= IDLE;
            end else begin
              n_q     <= n_q + 1'b1;
              k_q     <= '0;
              acc_q   <= bias_sh;
              state_q <= MAC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MLP_LAYER_ARGMAX_EN
  logic signed [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]         amax_q;

  // Strict compare keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q  <= {1'b1, {(DATA_W-1){1'b0}}};
      amax_q <= '0;
    end else if (hs) begin
      max_q  <= {1'b1, {(DATA_W-1){1'b0}}};
      amax_q <= '0;
    end else if (state_q == ACT && $signed(act) > max_q) begin
      max_q  <= $signed(act);
      amax_q <= n_q;
    end
  end

  assign out_argmax = amax_q;
`endif

  assign cfg_busy  = ~idle;
  assign in_ready  = idle;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Bench for mlp_layer_seq: two instances (FRAC=0/ReLU and FRAC=4/identity)
// share stimulus; MLP_LAYER_ARGMAX_EN adds argmax checks.
module tb_mlp_layer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic       busy0, busy1, ir0, ir1, ov0, ov1, ol0, ol1;
  logic [7:0] od0, od1;
  logic       oi0, oi1;
`ifdef MLP_LAYER_ARGMAX_EN
  logic       am0, am1;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  mlp_layer_seq #(
    .DATA_W(8), .N_IN(4), .N_OUT(2), .FRAC(0), .ACT_MODE(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_busy(busy0),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_idx(oi0),
`ifdef MLP_LAYER_ARGMAX_EN
    .out_argmax(am0),
`endif
    .out_last(ol0)
  );

  mlp_layer_seq #(
    .DATA_W(8), .N_IN(4), .N_OUT(2), .FRAC(4), .ACT_MODE(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_busy(busy1),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_idx(oi1),
`ifdef MLP_LAYER_ARGMAX_EN
    .out_argmax(am1),
`endif
    .out_last(ol1)
  );

  typedef struct packed {
    logic [7:0][7:0] w;
    logic [1:0][7:0] b;
    logic [3:0][7:0] x;
    logic [1:0][7:0] e0;
    logic [1:0][7:0] e1;
    logic            am0;
    logic            am1;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic load_cfg(input int i);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(j); cfg_wdata = tv[i].w[j];
    end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(8 + n); cfg_wdata = tv[i].b[n];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_vec(input logic [31:0] x);
    @(negedge clk);
    in_data = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int c0, output int cnt);
    cnt = c0;
    while (!ov0 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic run_vec(input int i, input bit load);
    int cnt;
    if (load) load_cfg(i);
    start_vec(tv[i].x);
    for (int n = 0; n < 2; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        wait_ov(1, cnt);
      end else begin
        wait_ov(0, cnt);
      end
      chk($sformatf("v%0d_n%0d_lat", i, n), cnt, (n == 0) ? 5 : 6);
      chk($sformatf("v%0d_n%0d_ov1", i, n), int'(ov1), 1);
      chk($sformatf("v%0d_n%0d_u0", i, n), int'(od0), int'(tv[i].e0[n]));
      chk($sformatf("v%0d_n%0d_u1", i, n), int'(od1), int'(tv[i].e1[n]));
      chk($sformatf("v%0d_n%0d_idx", i, n), int'(oi0), n);
      chk($sformatf("v%0d_n%0d_last", i, n), int'(ol0), int'(n == 1));
`ifdef MLP_LAYER_ARGMAX_EN
      if (n == 1) begin
        chk($sformatf("v%0d_am0", i), int'(am0), int'(tv[i].am0));
        chk($sformatf("v%0d_am1", i), int'(am1), int'(tv[i].am1));
      end
`endif
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", i), int'(ir0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit stable;

    tv[0] = '{w: {8{8'h01}}, b: {8'd5, 8'd0},
              x: {8'd4, 8'd3, 8'd2, 8'd1},
              e0: {8'd15, 8'd10}, e1: {8'd5, 8'd0},
              am0: 1'b1, am1: 1'b1};
    tv[1] = '{w: {{4{8'h81}}, {4{8'h7F}}}, b: {8'd0, 8'd0},
              x: {4{8'h7F}},
              e0: {8'd0, 8'd127}, e1: {8'h80, 8'd127},
              am0: 1'b0, am1: 1'b0};
    tv[2] = '{w: {{4{8'hFE}}, {4{8'h18}}}, b: {8'hFD, 8'h10},
              x: {4{8'h03}},
              e0: {8'd0, 8'd127}, e1: {8'hFB, 8'd34},
              am0: 1'b0, am1: 1'b0};
    tv[3] = '{w: {8'hF8, 8'h02, 8'h00, 8'hFF, 8'h04, 8'h03, 8'h02, 8'h01},
              b: {8'd10, 8'd0},
              x: {8'h02, 8'h07, 8'hFD, 8'h05},
              e0: {8'd3, 8'd28}, e1: {8'd9, 8'd1},
              am0: 1'b0, am1: 1'b1};
    tv[4] = '{w: '0, b: {8'd100, 8'h9C},
              x: {4{8'd9}},
              e0: {8'd100, 8'd0}, e1: {8'd100, 8'h9C},
              am0: 1'b1, am1: 1'b1};
    tv[5] = '{w: '0, b: '0,
              x: {4{8'd1}},
              e0: '0, e1: '0,
              am0: 1'b0, am1: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", int'(ov0), 0);
    chk("rst_ir", int'(ir0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_od", int'(od0), 0);
    chk("rst_idx", int'(oi0), 0);
    chk("rst_last", int'(ol0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, 1'b1);

    // Backpressure on neuron 0
    load_cfg(0);
    out_ready = 1'b0;
    start_vec(tv[0].x);
    wait_ov(0, cnt);
    chk("bp_lat", cnt, 5);
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!ov0 || od0 != 8'd10 || oi0 != 1'b0 || ir0) stable = 1'b0;
    end
    chk("bp_hold", int'(stable), 1);
    chk("bp_busy", int'(busy0), 1);
    @(negedge clk);
    out_ready = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!ov0 && cnt < 100);
    chk("bp_gap", cnt, 6);
    chk("bp_idx", int'(oi0), 1);
    chk("bp_data", int'(od0), 15);
    @(posedge clk); #1;
    chk("bp_idle", int'(ir0), 1);

    // Config write during MAC must be dropped
    start_vec(tv[0].x);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 8'd50;
    chk("lk_busy", int'(busy0), 1);
    @(negedge clk);
    cfg_we = 1'b0;
    wait_ov(0, cnt);
    chk("lk_u0", int'(od0), 10);
    chk("lk_u1", int'(od1), 0);
    @(posedge clk); #1;
    wait_ov(1, cnt);
    chk("lk_n1", int'(od0), 15);
    @(posedge clk); #1;
    run_vec(0, 1'b0);

    // Reset in the middle of MAC
    start_vec(tv[0].x);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_ov", int'(ov0), 0);
    chk("mr_ir", int'(ir0), 1);
    chk("mr_busy", int'(busy0), 0);
    chk("mr_od", int'(od0), 0);
    chk("mr_last", int'(ol0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
